// File: rtl/lcd_command_sender.sv
// lcd_command_sender
// Writes one 10-bit transfer (RS, RW, 8-bit byte) to an HD44780-compatible
// LCD in 4-bit mode: upper nibble, gap, lower nibble, then the controller
// execution wait. Every phase is timed by a single shared down-counter.
module lcd_command_sender #(
    parameter int T_SETUP = 2,     // nibble/RS/RW valid to lcd_e rising
    parameter int T_PULSE = 12,    // lcd_e high time
    parameter int T_HOLD  = 1,     // nibble held after lcd_e falls
    parameter int T_GAP   = 50,    // upper-to-lower nibble spacing
    parameter int T_WAIT  = 2000   // execution time after the lower nibble
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rs_in,
    input  logic       rw_in,
    input  logic [7:0] data_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] sf_d,
    output logic       ready
);

    // The counter must hold the largest (count - 1) of any phase.
    localparam int MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int MAX_B = (T_HOLD  > T_GAP)   ? T_HOLD  : T_GAP;
    localparam int MAX_C = (MAX_A   > MAX_B)   ? MAX_A   : MAX_B;
    localparam int MAX_T = (MAX_C   > T_WAIT)  ? MAX_C   : T_WAIT;
    localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    // A phase of length T loads T-1 and leaves when the counter reads 0,
    // so it occupies exactly T cycles.
    localparam logic [CNT_W-1:0] LOAD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LOAD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LOAD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LOAD_GAP   = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] LOAD_WAIT  = CNT_W'(T_WAIT - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP_HI,
        ST_PULSE_HI,
        ST_HOLD_HI,
        ST_GAP,
        ST_SETUP_LO,
        ST_PULSE_LO,
        ST_HOLD_LO,
        ST_WAIT
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             load_latch;
    logic             rs_q, rw_q;
    logic [7:0]       data_q;

    logic             cnt_done;
    assign cnt_done = (cnt == '0);

    // State, phase counter and the transfer latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: every register here, latches included, is cleared on reset so
            // the outputs are defined from the first cycle after the reset edge.
            state  <= ST_IDLE;
            cnt    <= '0;
            rs_q   <= 1'b0;
            rw_q   <= 1'b0;
            data_q <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples the values
            // of the previous cycle, independent of statement order.
            state <= state_next;
            cnt   <= cnt_next;
            if (load_latch) begin
                rs_q   <= rs_in;
                rw_q   <= rw_in;
                data_q <= data_in;
            end
        end
    end

    // Next-state logic: each phase counts down, then loads the next phase.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        cnt_next   = cnt;
        load_latch = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETUP_HI;
                    cnt_next   = LOAD_SETUP;
                    load_latch = 1'b1;
                end
            end
            ST_SETUP_HI: begin
                if (cnt_done) begin
                    state_next = ST_PULSE_HI;
                    cnt_next   = LOAD_PULSE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_PULSE_HI: begin
                if (cnt_done) begin
                    state_next = ST_HOLD_HI;
                    cnt_next   = LOAD_HOLD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_HOLD_HI: begin
                if (cnt_done) begin
                    state_next = ST_GAP;
                    cnt_next   = LOAD_GAP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_done) begin
                    state_next = ST_SETUP_LO;
                    cnt_next   = LOAD_SETUP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_SETUP_LO: begin
                if (cnt_done) begin
                    state_next = ST_PULSE_LO;
                    cnt_next   = LOAD_PULSE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_PULSE_LO: begin
                if (cnt_done) begin
                    state_next = ST_HOLD_LO;
                    cnt_next   = LOAD_HOLD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_HOLD_LO: begin
                if (cnt_done) begin
                    state_next = ST_WAIT;
                    cnt_next   = LOAD_WAIT;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_done) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode from the registered state and latches only (glitch-free).
    always_comb begin
        ready  = (state == ST_IDLE);
        lcd_e  = 1'b0;
        sf_d   = 4'h0;
        lcd_rs = 1'b0;
        lcd_rw = 1'b0;
        if (state != ST_IDLE) begin
            lcd_rs = rs_q;
            lcd_rw = rw_q;
        end
        case (state)
            ST_SETUP_HI, ST_HOLD_HI: sf_d = data_q[7:4];
            ST_PULSE_HI: begin
                sf_d  = data_q[7:4];
                lcd_e = 1'b1;
            end
            ST_SETUP_LO, ST_HOLD_LO: sf_d = data_q[3:0];
            ST_PULSE_LO: begin
                sf_d  = data_q[3:0];
                lcd_e = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lcd_command_sender.sv
// Self-checking bench for lcd_command_sender: directed scenarios plus random
// traffic, compared every cycle against a cycle-offset reference model.
module tb_lcd_command_sender;

    localparam int A   = 2;      // T_SETUP
    localparam int P   = 12;     // T_PULSE
    localparam int H   = 1;      // T_HOLD
    localparam int G   = 50;     // T_GAP
    localparam int W   = 2000;   // T_WAIT
    localparam int WIN = A + P + H;
    localparam int N   = 2 * WIN + G + W;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rs_in = 1'b0;
    logic       rw_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       lcd_rs, lcd_rw, lcd_e, ready;
    logic [3:0] sf_d;

    lcd_command_sender #(
        .T_SETUP(A), .T_PULSE(P), .T_HOLD(H), .T_GAP(G), .T_WAIT(W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .rs_in(rs_in), .rw_in(rw_in),
        .data_in(data_in), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .sf_d(sf_d), .ready(ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: busy flag plus offset (cycles since the accept edge).
    bit       m_busy = 1'b0;
    int       m_t = 0;
    bit       m_rs, m_rw;
    bit [7:0] m_data;

    // Monitors on the DUT side.
    int  e_rises = 0;
    bit  e_prev = 1'b0;
    int  acc_cnt = 0;
    int  acc_prev = 0;
    int  acc_last = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, actual, expected);
        end
    endtask

    // Expected {ready, lcd_e, lcd_rs, lcd_rw, sf_d} for the current cycle.
    function automatic logic [7:0] model_out();
        logic       e;
        logic [3:0] nib;
        int         u;
        if (!m_busy) return 8'b1000_0000;
        e   = 1'b0;
        nib = 4'h0;
        if (m_t <= WIN) begin
            nib = m_data[7:4];
            e   = (m_t > A) && (m_t <= A + P);
        end else if (m_t > WIN + G && m_t <= 2 * WIN + G) begin
            u   = m_t - (WIN + G);
            nib = m_data[3:0];
            e   = (u > A) && (u <= A + P);
        end
        return {1'b0, e, m_rs, m_rw, nib};
    endfunction

    // One clock: apply inputs, advance the model over the edge, compare at negedge.
    task automatic step(input logic r, input logic s, input logic rs, input logic rw,
                        input logic [7:0] d);
        reset   = r;
        start   = s;
        rs_in   = rs;
        rw_in   = rw;
        data_in = d;
        if (!r && s && ready) begin
            acc_cnt++;
            acc_prev = acc_last;
            acc_last = cyc + 1;
        end
        if (r) begin
            m_busy = 1'b0;
            m_t    = 0;
        end else if (!m_busy) begin
            if (s) begin
                m_busy = 1'b1;
                m_t    = 1;
                m_rs   = rs;
                m_rw   = rw;
                m_data = d;
            end
        end else if (m_t == N) begin
            m_busy = 1'b0;
            m_t    = 0;
        end else begin
            m_t++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (lcd_e && !e_prev) e_rises++;
        e_prev = lcd_e;
        check("outputs", {24'h0, ready, lcd_e, lcd_rs, lcd_rw, sf_d}, {24'h0, model_out()});
    endtask

    task automatic idle(input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rs_in, rw_in, d);
    endtask

    initial begin
        @(negedge clk);

        // Reset held two cycles, then released.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("reset_ready", {31'h0, ready}, 32'd1);
        check("reset_idle_outs", {27'h0, lcd_e, lcd_rs, lcd_rw, sf_d}, 32'd0);
        idle(3, 8'h00);

        // Command 0x28.
        e_rises = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h28);
        idle(N, 8'h28);
        check("cmd28_pulses", e_rises, 32'd2);
        check("cmd28_ready", {31'h0, ready}, 32'd1);

        // Data 0x41 with the inputs changed mid-transfer.
        e_rises = 0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h41);
        idle(20, 8'h41);
        rs_in = 1'b0;
        idle(N - 20, 8'hFF);
        check("data41_pulses", e_rises, 32'd2);

        // Start pulsed at cycle 500 of a transfer is ignored.
        e_rises = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
        idle(498, 8'h01);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
        idle(N - 499, 8'h01);
        check("midpulse_pulses", e_rises, 32'd2);
        check("midpulse_accepts", acc_cnt, 32'd3);

        // Start held through two back-to-back transfers 0x06 then 0x0C.
        e_rises = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h06);
        for (int i = 0; i < N + 1; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h0C);
        idle(N, 8'h0C);
        check("b2b_spacing", acc_last - acc_prev, N + 1);
        check("b2b_pulses", e_rises, 32'd4);
        check("b2b_accepts", acc_cnt, 32'd5);

        // Reset during PULSE_LO aborts; the next transfer completes.
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
        idle(WIN + G + A + 4, 8'h33);
        check("pulse_lo_e", {31'h0, lcd_e}, 32'd1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h33);
        check("abort_idle", {24'h0, ready, lcd_e, lcd_rs, lcd_rw, sf_d}, 32'h80);
        e_rises = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h01);
        idle(N, 8'h01);
        check("after_abort_pulses", e_rises, 32'd2);

        // Random traffic: random inputs every cycle, sparse starts, rare resets.
        for (int i = 0; i < 30000; i++) begin
            step(($urandom_range(0, 5999) == 0), ($urandom_range(0, 15) == 0),
                 1'($urandom), 1'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
